// File: rtl/bcd_entry_to_bin.sv
// Decimal keypad entry register with a reverse double-dabble BCD-to-binary converter.
// Digits enter most significant first; each conversion takes one clock per result bit.
module bcd_entry_to_bin #(
    parameter int DW   = 16,
    parameter int NDIG = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [3:0]        digit_in_i,
    input  logic              digit_valid_i,
    input  logic              convert_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DW-1:0]     bin_out_o,
    output logic              ovf_o,
    output logic              bad_digit_o,
    output logic [2:0]        digit_count_o,
    output logic [4*NDIG-1:0] bcd_entry_o
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] entry_q, entry_d;
    logic [2:0]    count_q, count_d;
    logic [BW-1:0] work_bcd_q, work_bcd_d;
    logic [DW-1:0] work_bin_q, work_bin_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [DW-1:0] bin_q, bin_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          bad_q, bad_d;

    logic [BW-1:0] shift_bcd, adj_bcd;
    logic [DW-1:0] shift_bin;

    // One iteration: halve the BCD value; a nibble that received a carried-in 1 (>=8) is off by 3.
    always_comb begin
        shift_bcd = {1'b0, work_bcd_q[BW-1:1]};
        shift_bin = {work_bcd_q[0], work_bin_q[DW-1:1]};
        adj_bcd   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (shift_bcd[4*i +: 4] >= 4'd8)
                adj_bcd[4*i +: 4] = shift_bcd[4*i +: 4] - 4'd3;
            else
                adj_bcd[4*i +: 4] = shift_bcd[4*i +: 4];
        end
    end

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        count_d    = count_q;
        work_bcd_d = work_bcd_q;
        work_bin_d = work_bin_q;
        iter_d     = iter_q;
        bin_d      = bin_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bad_d      = bad_q;

        if (clear_i) begin
            state_d = IDLE;
            entry_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            bad_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (convert_i) begin
                        work_bcd_d = entry_q;
                        work_bin_d = '0;
                        iter_d     = '0;
                        state_d    = CONV;
                    end else if (digit_valid_i) begin
                        if (digit_in_i > 4'd9) begin
                            bad_d = 1'b1;
                        end else if (count_q < 3'(NDIG)) begin
                            entry_d = {entry_q[BW-5:0], digit_in_i};
                            count_d = count_q + 3'd1;
                        end
                    end
                end
                CONV: begin
                    work_bcd_d = adj_bcd;
                    work_bin_d = shift_bin;
                    iter_d     = iter_q + CW'(1);
                    if (iter_q == CW'(DW - 1))
                        state_d = DONE;
                end
                DONE: begin
                    // Any BCD residue left after DW halvings means the value did not fit.
                    bin_d   = work_bin_q;
                    ovf_d   = (work_bcd_q != '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            entry_q    <= '0;
            count_q    <= '0;
            work_bcd_q <= '0;
            work_bin_q <= '0;
            iter_q     <= '0;
            bin_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            count_q    <= count_d;
            work_bcd_q <= work_bcd_d;
            work_bin_q <= work_bin_d;
            iter_q     <= iter_d;
            bin_q      <= bin_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
        end
    end

    assign busy_o        = (state_q == CONV);
    assign done_o        = done_q;
    assign bin_out_o     = bin_q;
    assign ovf_o         = ovf_q;
    assign bad_digit_o   = bad_q;
    assign digit_count_o = count_q;
    assign bcd_entry_o   = entry_q;

endmodule
